// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings and helpers for the memory-mapped countdown timer
//
// Purpose: FSM state encoding, register word offsets, CTRL bit indices and a
// byte-lane merge helper, imported by timer_counter.
// Ports: none (package).

package timer_pkg;

  // Countdown state machine encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Word offsets within a timer window (bus Addr[3:2]).
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // CTRL bit indices.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE value selecting auto-reload; every other value runs one-shot.
  localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

  // Replace the byte lanes of old_w selected by be_w with the matching lanes of new_w.
  function automatic logic [31:0] merge_be(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be_w
  );
    logic [31:0] result;
    result = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be_w[i]) begin
        result[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with CTRL/PRESET/COUNT and masked interrupt
//
// Purpose: one timer window on the processor bus. Software programs PRESET and
// CTRL; the FSM loads COUNT from PRESET, counts down to zero and raises an
// internal flag, which is exported as irq when CTRL.IM is set.
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset
//   addr   - word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 unused
//   we     - write strobe, already qualified by window hit
//   be     - byte enables for wdata
//   wdata  - write data
//   rdata  - combinational read data for addr
//   irq    - CTRL.IM & internal flag

module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             irq_flag_q;
  timer_state_e     state_q;

  logic [CNT_W-1:0] preset_d;
  logic             auto_reload;
  logic             wr_any;
  logic             wr_ctrl;
  logic             wr_preset;

  assign auto_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO_RELOAD);
  assign wr_any      = we && (be != 4'b0000);
  assign wr_ctrl     = wr_any && (addr == REG_CTRL);
  assign wr_preset   = wr_any && (addr == REG_PRESET);

  // PRESET is held narrower than the bus when CNT_W < 32; lanes above CNT_W drop.
  assign preset_d = CNT_W'(merge_be(32'(preset_q), wdata, be));

  // Registers and FSM. The bus-write assignments come after the FSM ones so
  // that, on the same edge, software wins over the FSM (EN clear, flag set).
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 4'b0000;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_q[CTRL_EN]) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_q[CTRL_EN]) begin
            // Pause: COUNT holds, re-enable goes through LOAD again.
            state_q <= ST_IDLE;
          end else if (count_q > CNT_W'(1)) begin
            count_q <= count_q - CNT_W'(1);
          end else begin
            // COUNT of 1 or 0 both expire here, so PRESET = 0 acts like 1.
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= ST_INT;
          end
        end
        ST_INT: begin
          state_q <= ST_IDLE;
          if (auto_reload) begin
            irq_flag_q <= 1'b0;
          end else begin
            ctrl_q[CTRL_EN] <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (wr_ctrl || wr_preset) begin
        irq_flag_q <= 1'b0;
      end
      // Only lane 0 of CTRL is stored.
      if (wr_ctrl && be[0]) begin
        ctrl_q <= wdata[3:0];
      end
      if (wr_preset) begin
        preset_q <= preset_d;
      end
    end
  end

  // Read mux; COUNT and offset 3 are read-only / unmapped.
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      REG_CTRL:   rdata = {28'h000_0000, ctrl_q};
      REG_PRESET: rdata = 32'(preset_q);
      REG_COUNT:  rdata = 32'(count_q);
      default:    rdata = 32'h0000_0000;
    endcase
  end

  assign irq = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed self-checking bench for timer_counter

module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks;
  int failures;

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    addr  = a;
    be    = b;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    be    = 4'b0000;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    we    = 1'b0;
    be    = 4'b0000;
    addr  = 2'd0;
    wdata = 32'h0;
    step();
    step();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_read addr=%0d actual=%h required=%h", a, d, 32'h0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq actual=%b required=0", irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    bus_write(2'd1, 4'hF, 32'd5);
    bus_write(2'd0, 4'hF, 32'h9);
    // Now just after edge N (the CTRL write edge).
    step(); // N+1: IDLE -> LOAD
    for (int k = 2; k <= 7; k++) begin
      step();
      bus_read(2'd2, d);
      checks++;
      if (d !== 32'(7 - k)) begin
        failures++;
        $display("FAIL oneshot_count edge=N+%0d actual=%0d required=%0d", k, d, 7 - k);
      end
      checks++;
      if (irq !== (k == 7)) begin
        failures++;
        $display("FAIL oneshot_irq edge=N+%0d actual=%b required=%b", k, irq, (k == 7));
      end
    end
    step(); // N+8: INT -> IDLE, EN cleared
    step();
    step();
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h8) begin
      failures++;
      $display("FAIL oneshot_ctrl actual=%h required=%h", d, 32'h8);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_irq_held actual=%b required=1", irq);
    end
    bus_write(2'd1, 4'hF, 32'd5);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_irq_clear actual=%b required=0", irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic        exp;
    bus_write(2'd1, 4'hF, 32'd3);
    bus_write(2'd0, 4'hF, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      step();
      exp = (k == 5) || (k == 11) || (k == 17);
      checks++;
      if (irq !== exp) begin
        failures++;
        $display("FAIL autoreload_irq edge=N+%0d actual=%b required=%b", k, irq, exp);
      end
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hB) begin
      failures++;
      $display("FAIL autoreload_ctrl actual=%h required=%h", d, 32'hB);
    end
    bus_write(2'd0, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_masked();
    bus_write(2'd1, 4'hF, 32'd10);
    bus_write(2'd0, 4'hF, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL masked_irq edge=N+%0d actual=%b required=0", k, irq);
      end
    end
    checks++;
    if (dut.irq_flag_q !== 1'b1) begin
      failures++;
      $display("FAIL masked_flag_set actual=%b required=1", dut.irq_flag_q);
    end
    step();
    bus_write(2'd0, 4'hF, 32'h8);
    checks++;
    if (dut.irq_flag_q !== 1'b0) begin
      failures++;
      $display("FAIL masked_flag_clear actual=%b required=0", dut.irq_flag_q);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL masked_irq_after actual=%b required=0", irq);
    end
  endtask

  task automatic test_pause();
    logic [31:0] d;
    // PRESET is still 10.
    bus_write(2'd0, 4'hF, 32'h1);
    // COUNT = 10 after N+2, so 7 after N+5; the CTRL write at N+6 still decrements to 6.
    for (int k = 1; k <= 5; k++) step();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd7) begin
      failures++;
      $display("FAIL pause_pre actual=%0d required=7", d);
    end
    bus_write(2'd0, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) step();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd6) begin
      failures++;
      $display("FAIL pause_frozen actual=%0d required=6", d);
    end
    bus_write(2'd2, 4'hF, 32'h0000FFFF);
    bus_write(2'd3, 4'hF, 32'hDEADBEEF);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd6) begin
      failures++;
      $display("FAIL count_write_ignored actual=%h required=%h", d, 32'd6);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL addr3_read actual=%h required=%h", d, 32'h0);
    end
    bus_write(2'd0, 4'hF, 32'h1);
    step(); // M+1: IDLE -> LOAD
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd6) begin
      failures++;
      $display("FAIL reenable_before_load actual=%0d required=6", d);
    end
    step(); // M+2: COUNT <= PRESET
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd10) begin
      failures++;
      $display("FAIL reenable_reload actual=%0d required=10", d);
    end
    bus_write(2'd0, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_boundaries();
    // PRESET = 0 expires like PRESET = 1: flag rises at N+3.
    bus_write(2'd1, 4'hF, 32'd0);
    bus_write(2'd0, 4'hF, 32'h9);
    step();
    step();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL preset0_early actual=%b required=0", irq);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL preset0_irq actual=%b required=1", irq);
    end
    for (int k = 0; k < 3; k++) step();
    // PRESET = 1; a PRESET write on the CNT -> INT edge must leave the flag clear.
    bus_write(2'd1, 4'hF, 32'd1);
    bus_write(2'd0, 4'hF, 32'h9);
    step();
    step();
    bus_write(2'd1, 4'hF, 32'd1); // edge N+3
    checks++;
    if (dut.irq_flag_q !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL write_beats_expire flag=%b irq=%b required=0", dut.irq_flag_q, irq);
    end
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_byte_enable_reset();
    logic [31:0] d;
    bus_write(2'd1, 4'hF, 32'h11223344);
    bus_write(2'd1, 4'h4, 32'h00AA0000);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h11AA3344) begin
      failures++;
      $display("FAIL byte_enable actual=%h required=%h", d, 32'h11AA3344);
    end
    bus_write(2'd0, 4'hF, 32'h9);
    for (int k = 1; k <= 5; k++) step();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h11AA3341) begin
      failures++;
      $display("FAIL midcount_value actual=%h required=%h", d, 32'h11AA3341);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL midcount_reset addr=%0d actual=%h required=%h", a, d, 32'h0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL midcount_reset_irq actual=%b required=0", irq);
    end
    step();
    step();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_stays_idle actual=%h required=%h", d, 32'h0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_pause();
    test_boundaries();
    test_byte_enable_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped countdown timer on the processor bus, downstream of the data-memory stage.
- The data-memory stage asserts PrWE/PrBE for addresses 0x7f00–0x7f0b and 0x7f10–0x7f1b. The bridge decodes these and hands one window to each timer instance.
- Each instance exposes three word registers (CTRL, PRESET, COUNT) and one interrupt line into the CP0 hardware-interrupt vector.
- Two instances are built: one at 0x7f00 and one at 0x7f10.

Parameters:
- CNT_W, 32, width of PRESET and COUNT. Must be ≤ 32; upper read bits are 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- addr  in  2  word offset within the window (bus Addr[3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- we  in  1  write strobe from the bridge (PrWE qualified by window hit).
- be  in  4  byte enables (PrBE); bit i enables wdata[8i+7:8i].
- wdata  in  32  write data.
- rdata  out  32  combinational read data for addr.
- irq  out  1  interrupt request = CTRL.IM & irq_flag.

Behaviour:
- CTRL layout:
  - bit0 = EN (enable).
  - bits2:1 = MODE (00 one-shot; 01 auto-reload; 10/11 behave as 00, stored and read back as written).
  - bit3 = IM (interrupt mask).
  - bits31:4 read 0 and are not stored.
- Reset: CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE, so irq = 0. rdata follows addr even during reset.
- Writes:
  - On posedge clk when we = 1, the selected register is updated byte-lane by byte-lane per be. Unselected lanes keep their value.
  - Writes to COUNT (addr = 2) and addr = 3 are ignored.
  - Any write to CTRL or PRESET (any be ≠ 0) clears irq_flag in the same edge.
- Reads: rdata = {28'b0, CTRL[3:0]}, PRESET, COUNT, or 0, selected by addr. Pure combinational, zero latency. A value written at edge N is visible after edge N.
- State machine (2-bit state, updated every posedge unless reset):
  - IDLE: if EN -> LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - if !EN -> IDLE, COUNT holds (pause; re-enable reloads from PRESET).
    - else if COUNT > 1: COUNT <= COUNT - 1, stay.
    - else (COUNT is 1 or 0): COUNT <= 0, irq_flag <= 1, -> INT.
  - INT: -> IDLE.
    - MODE = 01: irq_flag <= 0 in this edge, giving a 1-cycle flag pulse. EN stays 1, so the sequence IDLE -> LOAD -> CNT repeats.
    - MODE = 00/10/11: EN <= 0 and irq_flag is held until software writes CTRL or PRESET.
- Period:
  - PRESET = P ≥ 1: irq_flag rises P+2 edges after the edge that sets EN.
  - PRESET = 0 behaves like P = 1.
  - Auto-reload period is P+3 edges.
- Simultaneous events:
  - A bus write to CTRL and a state-machine update of EN in the same edge: the bus write wins on written lanes.
  - A bus write to PRESET during CNT does not affect the current COUNT; it takes effect at the next LOAD.
  - A CTRL/PRESET write in the same edge as CNT -> INT: the write's clear wins, so irq_flag = 0.
- Reset mid-count returns all registers to 0 and the state to IDLE in one edge.
- No exception logic: illegal sizes and addresses are filtered upstream.

Decomposition:
- Package timer_pkg:
  - state encodings IDLE = 0, LOAD = 1, CNT = 2, INT = 3;
  - register offsets REG_CTRL = 0, REG_PRESET = 1, REG_COUNT = 2;
  - CTRL bit indices EN = 0, MODE_LO = 1, MODE_HI = 2, IM = 3;
  - function merge_be(old, new, be) returning the byte-masked word.
- No sub-module. A single always block for the registers and FSM, plus one combinational read mux.

Test Plan:
- Reset, then read addr 0/1/2 -> rdata = 0 each; irq = 0.
- Write PRESET = 5 (be = 1111), write CTRL = 0x9 (EN, IM, mode 0) -> COUNT reads 5, 4, 3, 2, 1, 0; irq rises 7 edges after the CTRL write edge and stays 1; CTRL reads 0x8; a PRESET write drops irq.
- PRESET = 3, CTRL = 0xB (auto-reload, IM) -> irq is a 1-cycle pulse every 6 edges, for 3 periods; CTRL stays 0xB.
- PRESET = 10, CTRL = 0x1 (IM = 0) -> irq stays 0 throughout; internal flag is set; later write CTRL = 0x8 -> flag cleared, irq stays 0.
- Mid-count at COUNT = 6, write CTRL = 0x0 -> COUNT frozen at 6 (state to IDLE). Re-write CTRL = 0x1 -> COUNT reloads to PRESET, not 6. Write addr 2 = 0xFFFF -> COUNT unchanged.
- Byte enables: PRESET = 0x11223344, then write be = 0100 with data 0x00AA0000 -> reads 0x11AA3344. Reset asserted mid-count -> all registers read 0 next cycle.
